// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU command encodings,
// NZCV bit positions inside the 4-bit status word, and FSM states.
package exe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  // Bit positions inside a status word laid out as {N, Z, C, V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_MUL  = 1'b1;

endpackage

// File: rtl/exe_alu.sv
// Single-cycle combinational ALU. Add and subtract share one adder:
// subtraction feeds the inverted operand plus a carry-in, so the adder's
// carry-out is directly the ARM-style not-borrow.
module exe_alu
  import exe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              c_in,
  input  logic              v_in,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  logic              arith;
  logic              carry_in;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] logic_res;
  logic [DATA_W:0]   sum;

  // Decode the command, run the shared adder and derive NZCV.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; a missing default would infer a latch.
    arith     = 1'b0;
    carry_in  = 1'b0;
    b_eff     = op_b;
    logic_res = op_b;
    unique case (cmd)
      CMD_MVN: logic_res = ~op_b;
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin arith = 1'b1; carry_in = c_in; end
      CMD_SUB: begin arith = 1'b1; b_eff = ~op_b; carry_in = 1'b1; end
      CMD_SBC: begin arith = 1'b1; b_eff = ~op_b; carry_in = c_in; end
      CMD_AND: logic_res = op_a & op_b;
      CMD_ORR: logic_res = op_a | op_b;
      CMD_EOR: logic_res = op_a ^ op_b;
      default: logic_res = op_b;  // MOV and every unassigned code
    endcase

    sum    = {1'b0, op_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, carry_in};
    result = arith ? sum[DATA_W-1:0] : logic_res;

    flags[FLAG_N] = result[DATA_W-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = arith ? sum[DATA_W] : c_in;
    // Overflow: both adder inputs share a sign that the sum does not.
    flags[FLAG_V] = arith ? ((op_a[DATA_W-1] == b_eff[DATA_W-1]) &&
                             (sum[DATA_W-1] != op_a[DATA_W-1])) : v_in;
  end

endmodule

// File: rtl/exe_stage_pipe.sv
// Execute pipeline stage: operand forwarding, single-cycle ALU ops, a
// bit-serial shift-add multiplier, and the EXE/MEM output register.
// MUL occupies the stage for DATA_W cycles while upstream is held via busy.
module exe_stage_pipe
  import exe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int FWD_SRCS   = 2,
  parameter int SEL_W      = $clog2(FWD_SRCS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       flush,
  input  logic                       hold,
  input  logic                       wb_en_in,
  input  logic                       mem_r_en_in,
  input  logic                       mem_w_en_in,
  input  logic                       s_in,
  input  logic [3:0]                 exec_cmd,
  input  logic [DATA_W-1:0]          pc_in,
  input  logic [DATA_W-1:0]          val_1,
  input  logic [DATA_W-1:0]          val_2,
  input  logic [DATA_W-1:0]          val_r_m_in,
  input  logic [23:0]                signed_imm_24,
  input  logic [REG_ADDR_W-1:0]      dest_in,
  input  logic [3:0]                 status_in,
  input  logic [SEL_W-1:0]           sel_src1,
  input  logic [SEL_W-1:0]           sel_src2,
  input  logic [SEL_W-1:0]           sel_store,
  input  logic [FWD_SRCS*DATA_W-1:0] fwd_vals,
  output logic                       busy,
  output logic                       wb_en_out,
  output logic                       mem_r_en_out,
  output logic                       mem_w_en_out,
  output logic [DATA_W-1:0]          alu_res,
  output logic [DATA_W-1:0]          val_r_m_out,
  output logic [REG_ADDR_W-1:0]      dest_out,
  output logic [3:0]                 status_out,
  output logic                       status_wr,
  output logic [DATA_W-1:0]          branch_addr
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // Select 0 and any select beyond the last source keep the local operand.
  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic [SEL_W-1:0]           sel,
    input logic [DATA_W-1:0]          local_val,
    input logic [FWD_SRCS*DATA_W-1:0] fv
  );
    fwd_pick = local_val;
    for (int k = 1; k <= FWD_SRCS; k++) begin
      if (sel == SEL_W'(k)) fwd_pick = fv[(k-1)*DATA_W +: DATA_W];
    end
  endfunction

  logic [DATA_W-1:0] src1, src2, store_val;
  assign src1      = fwd_pick(sel_src1,  val_1,      fwd_vals);
  assign src2      = fwd_pick(sel_src2,  val_2,      fwd_vals);
  assign store_val = fwd_pick(sel_store, val_r_m_in, fwd_vals);

  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;

  exe_alu #(.DATA_W(DATA_W)) u_alu (
    .cmd    (exec_cmd),
    .op_a   (src1),
    .op_b   (src2),
    .c_in   (status_in[FLAG_C]),
    .v_in   (status_in[FLAG_V]),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // Branch target: word offset, sign-extended, wraps modulo 2^DATA_W.
  logic [DATA_W-1:0] imm_ext;
  assign imm_ext     = {{(DATA_W-24){signed_imm_24[23]}}, signed_imm_24};
  assign branch_addr = pc_in + (imm_ext << 2);

  // FSM, multiplier datapath, latched MUL instruction and output register.
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
  logic                  lat_wb_q, lat_wb_d, lat_mr_q, lat_mr_d;
  logic                  lat_mw_q, lat_mw_d, lat_s_q, lat_s_d;
  logic [REG_ADDR_W-1:0] lat_dest_q, lat_dest_d;
  logic [DATA_W-1:0]     lat_store_q, lat_store_d;
  logic                  wb_q, wb_d, mr_q, mr_d, mw_q, mw_d;
  logic [DATA_W-1:0]     res_q, res_d, store_q, store_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;

  logic              is_mul, accept, mul_last;
  logic [DATA_W-1:0] prod_next;

  assign is_mul    = (exec_cmd == CMD_MUL);
  assign accept    = (state_q == ST_IDLE) && in_valid && !flush && !hold;
  assign mul_last  = (state_q == ST_MUL) && (cnt_q == CNT_LAST);
  assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state logic: flush beats hold, hold freezes everything else.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    lat_wb_d    = lat_wb_q;
    lat_mr_d    = lat_mr_q;
    lat_mw_d    = lat_mw_q;
    lat_s_d     = lat_s_q;
    lat_dest_d  = lat_dest_q;
    lat_store_d = lat_store_q;
    wb_d        = wb_q;
    mr_d        = mr_q;
    mw_d        = mw_q;
    res_d       = res_q;
    store_d     = store_q;
    dest_d      = dest_q;

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      wb_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
    end else if (!hold) begin
      // A bubble loads unless a result is written below.
      wb_d = 1'b0;
      mr_d = 1'b0;
      mw_d = 1'b0;
      if (state_q == ST_IDLE) begin
        if (in_valid && is_mul) begin
          state_d     = ST_MUL;
          cnt_d       = '0;
          mcand_d     = src1;
          mplier_d    = src2;
          prod_d      = '0;
          lat_wb_d    = wb_en_in;
          lat_mr_d    = mem_r_en_in;
          lat_mw_d    = mem_w_en_in;
          lat_s_d     = s_in;
          lat_dest_d  = dest_in;
          lat_store_d = store_val;
        end else if (in_valid) begin
          res_d   = alu_result;
          wb_d    = wb_en_in;
          mr_d    = mem_r_en_in;
          mw_d    = mem_w_en_in;
          dest_d  = dest_in;
          store_d = store_val;
        end
      end else begin
        prod_d   = prod_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (mul_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          res_d   = prod_next;
          wb_d    = lat_wb_q;
          mr_d    = lat_mr_q;
          mw_d    = lat_mw_q;
          dest_d  = lat_dest_q;
          store_d = lat_store_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the multiplier and latched-instruction registers are cleared
      // too, so a reset mid-MUL leaves nothing behind to resurface later.
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      lat_wb_q    <= 1'b0;
      lat_mr_q    <= 1'b0;
      lat_mw_q    <= 1'b0;
      lat_s_q     <= 1'b0;
      lat_dest_q  <= '0;
      lat_store_q <= '0;
      wb_q        <= 1'b0;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
      res_q       <= '0;
      store_q     <= '0;
      dest_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      lat_wb_q    <= lat_wb_d;
      lat_mr_q    <= lat_mr_d;
      lat_mw_q    <= lat_mw_d;
      lat_s_q     <= lat_s_d;
      lat_dest_q  <= lat_dest_d;
      lat_store_q <= lat_store_d;
      wb_q        <= wb_d;
      mr_q        <= mr_d;
      mw_q        <= mw_d;
      res_q       <= res_d;
      store_q     <= store_d;
      dest_q      <= dest_d;
    end
  end

  // Status word: ALU flags normally; MUL rewrites only N and Z.
  always_comb begin
    status_out = alu_flags;
    if (state_q == ST_MUL) begin
      status_out[FLAG_N] = prod_next[DATA_W-1];
      status_out[FLAG_Z] = (prod_next == '0);
      status_out[FLAG_C] = status_in[FLAG_C];
      status_out[FLAG_V] = status_in[FLAG_V];
    end
  end

  // Incoming N and Z are always recomputed, never passed through.
  logic unused_nz;
  assign unused_nz = ^{status_in[FLAG_N], status_in[FLAG_Z]};

  assign busy      = rst && (hold || (accept && is_mul) ||
                             ((state_q == ST_MUL) && !mul_last));
  assign status_wr = rst && !hold && !flush &&
                     ((accept && !is_mul && s_in) || (mul_last && lat_s_q));

  assign wb_en_out    = wb_q;
  assign mem_r_en_out = mr_q;
  assign mem_w_en_out = mw_q;
  assign alu_res      = res_q;
  assign val_r_m_out  = store_q;
  assign dest_out     = dest_q;

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Bench for exe_stage_pipe: directed scenarios plus random ALU and MUL
// traffic compared against an arithmetic reference model.
module tb_exe_stage_pipe;

  localparam logic [3:0] C_MOV = 4'b0001, C_MVN = 4'b1001, C_ADD = 4'b0010,
                         C_ADC = 4'b0011, C_SUB = 4'b0100, C_SBC = 4'b0101,
                         C_AND = 4'b0110, C_ORR = 4'b0111, C_EOR = 4'b1000,
                         C_MUL = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, hold, wb_en_in, mem_r_en_in, mem_w_en_in, s_in;
  logic [3:0]  exec_cmd, status_in;
  logic [31:0] pc_in, val_1, val_2, val_r_m_in;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest_in;
  logic [1:0]  sel_src1, sel_src2, sel_store;
  logic [63:0] fwd_vals;
  logic        busy, wb_en_out, mem_r_en_out, mem_w_en_out, status_wr;
  logic [31:0] alu_res, val_r_m_out, branch_addr;
  logic [3:0]  dest_out, status_out;

  int total = 0;
  int bad   = 0;

  exe_stage_pipe dut (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .flush(flush), .hold(hold),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .s_in(s_in), .exec_cmd(exec_cmd), .pc_in(pc_in), .val_1(val_1),
    .val_2(val_2), .val_r_m_in(val_r_m_in), .signed_imm_24(signed_imm_24),
    .dest_in(dest_in), .status_in(status_in), .sel_src1(sel_src1),
    .sel_src2(sel_src2), .sel_store(sel_store), .fwd_vals(fwd_vals),
    .busy(busy), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .alu_res(alu_res), .val_r_m_out(val_r_m_out),
    .dest_out(dest_out), .status_out(status_out), .status_wr(status_wr),
    .branch_addr(branch_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1; combinational checks at posedge+3.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
    exec_cmd = cmd; val_1 = a; val_2 = b; s_in = s; in_valid = 1'b1;
    sel_src1 = 2'd0; sel_src2 = 2'd0; sel_store = 2'd0; flush = 1'b0; hold = 1'b0;
  endtask

  // Reference ALU from the arithmetic definitions of each command.
  function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                  input logic [31:0] b, input logic [3:0] st,
                                  output logic [31:0] res, output logic [3:0] f);
    longint unsigned ua, ub, us;
    longint sa, sb, ss;
    logic c, v, cin;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    c = st[1]; v = st[0]; cin = st[1];
    case (cmd)
      C_ADD, C_ADC: begin
        us  = ua + ub + ((cmd == C_ADC) ? longint'(cin) : 0);
        ss  = sa + sb + ((cmd == C_ADC) ? longint'(cin) : 0);
        res = us[31:0];
        c   = us[32];
        v   = (ss != longint'($signed(res)));
      end
      C_SUB, C_SBC: begin
        longint unsigned brw;
        brw = (cmd == C_SBC) ? longint'(!cin) : 0;
        res = a - b - brw[31:0];
        c   = (ua >= ub + brw);
        ss  = sa - sb - longint'(brw);
        v   = (ss != longint'($signed(res)));
      end
      C_MVN: res = ~b;
      C_AND: res = a & b;
      C_ORR: res = a | b;
      C_EOR: res = a ^ b;
      default: res = b;
    endcase
    f = {res[31], res == 32'd0, c, v};
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] local_v,
                                         input logic [63:0] fv);
    logic [31:0] slice [2];
    slice[0] = fv[31:0];
    slice[1] = fv[63:32];
    if (sel == 2'd1 || sel == 2'd2) return slice[sel - 2'd1];
    return local_v;
  endfunction

  // Runs one MUL; flush_at >= 0 aborts it in the cycle with that count.
  task automatic mul_test(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [3:0] st, input int flush_at);
    logic [63:0] p;
    logic [31:0] exp_res;
    p = 64'(a) * 64'(b);
    exp_res = p[31:0];
    set_op(C_MUL, a, b, s);
    wb_en_in = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; dest_in = 4'd5;
    status_in = st;
    settle();
    check("mul_accept_busy", busy, 1);
    check("mul_accept_swr", status_wr, 0);
    tick();
    check("mul_accept_bubble", wb_en_out, 0);
    for (int cnt = 0; cnt < 32; cnt++) begin
      // Noise on the data inputs must be ignored while multiplying.
      exec_cmd = C_ADD; val_1 = $urandom; val_2 = $urandom; dest_in = 4'($urandom);
      if (cnt == flush_at) begin
        flush = 1'b1;
        settle();
        check("flush_swr", status_wr, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        settle();
        check("flush_busy", busy, 0);
        check("flush_bubble", wb_en_out, 0);
        return;
      end
      settle();
      check("mul_busy", busy, (cnt < 31) ? 1 : 0);
      if (cnt == 31) begin
        check("mul_swr", status_wr, s);
        if (s) check("mul_status", status_out, {exp_res[31], exp_res == 32'd0, st[1:0]});
      end else begin
        check("mul_swr_mid", status_wr, 0);
      end
      tick();
      if (cnt < 31) check("mul_bubble", wb_en_out, 0);
    end
    in_valid = 1'b0;
    check("mul_res", alu_res, exp_res);
    check("mul_wb", wb_en_out, 1);
    check("mul_dest", dest_out, 5);
  endtask

  initial begin
    logic [31:0] r, ea, eb, es, exp_br;
    logic [3:0]  f, cmd;
    logic [3:0]  codes [15];
    int          off;

    codes = '{C_MOV, C_MVN, C_ADD, C_ADC, C_SUB, C_SBC, C_AND, C_ORR, C_EOR,
              4'h0, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    rst_n = 1'b0; in_valid = 1'b1; flush = 1'b0; hold = 1'b1; s_in = 1'b1;
    wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b1; exec_cmd = C_ADD;
    pc_in = '0; val_1 = 32'd1; val_2 = 32'd2; val_r_m_in = 32'd3;
    signed_imm_24 = '0; dest_in = 4'd1; status_in = '0;
    sel_src1 = '0; sel_src2 = '0; sel_store = '0; fwd_vals = '0;

    // Reset state, including strobes gated off while reset is low.
    #3;
    check("rst_busy", busy, 0);
    check("rst_swr", status_wr, 0);
    tick();
    check("rst_res", alu_res, 0);
    check("rst_wb", {wb_en_out, mem_r_en_out, mem_w_en_out}, 0);
    check("rst_dest", dest_out, 0);
    rst_n = 1'b1; hold = 1'b0; in_valid = 1'b0;
    tick();

    // ADD overflow into the sign bit.
    set_op(C_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
    wb_en_in = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; dest_in = 4'd3;
    status_in = 4'b0000;
    settle();
    check("add_busy", busy, 0);
    check("add_swr", status_wr, 1);
    check("add_nzcv", status_out, 4'b1001);
    tick();
    check("add_res", alu_res, 32'h8000_0000);
    check("add_dest", dest_out, 3);

    // SUB with src1 forwarded from slice 1.
    set_op(C_SUB, 32'd9, 32'd5, 1'b1);
    sel_src1 = 2'd2; fwd_vals = {32'd5, 32'h1234};
    settle();
    check("sub_swr", status_wr, 1);
    check("sub_nzcv", status_out, 4'b0110);
    tick();
    check("sub_res", alu_res, 0);

    // Random single-cycle traffic.
    for (int i = 0; i < 40; i++) begin
      cmd = codes[$urandom_range(0, 14)];
      set_op(cmd, $urandom, $urandom, 1'($urandom));
      sel_src1 = 2'($urandom); sel_src2 = 2'($urandom); sel_store = 2'($urandom);
      fwd_vals = {$urandom, $urandom}; val_r_m_in = $urandom; dest_in = 4'($urandom);
      status_in = 4'($urandom); wb_en_in = 1'($urandom); mem_r_en_in = 1'($urandom);
      mem_w_en_in = 1'($urandom); pc_in = $urandom; signed_imm_24 = 24'($urandom);
      ea = ref_fwd(sel_src1, val_1, fwd_vals);
      eb = ref_fwd(sel_src2, val_2, fwd_vals);
      es = ref_fwd(sel_store, val_r_m_in, fwd_vals);
      ref_alu(cmd, ea, eb, status_in, r, f);
      off = (signed_imm_24 >= 24'h80_0000) ? int'(signed_imm_24) - (1 << 24)
                                            : int'(signed_imm_24);
      exp_br = pc_in + 32'(off * 4);
      settle();
      check("rnd_busy", busy, 0);
      check("rnd_swr", status_wr, s_in);
      if (s_in) check("rnd_nzcv", status_out, f);
      check("rnd_branch", branch_addr, exp_br);
      tick();
      check("rnd_res", alu_res, r);
      check("rnd_store", val_r_m_out, es);
      check("rnd_dest", dest_out, dest_in);
      check("rnd_ctrl", {wb_en_out, mem_r_en_out, mem_w_en_out},
            {wb_en_in, mem_r_en_in, mem_w_en_in});
    end
    in_valid = 1'b0; sel_src1 = '0; sel_src2 = '0; sel_store = '0;
    tick();

    // Directed MUL: result 0, Z set, C and V carried through.
    mul_test(32'h0001_0000, 32'h0001_0000, 1'b1, 4'b0011, -1);
    for (int i = 0; i < 3; i++) mul_test($urandom, $urandom, 1'($urandom), 4'($urandom), -1);

    // MUL aborted by flush, then a 1-cycle op proves the stage is idle.
    mul_test(32'd7, 32'd9, 1'b1, 4'b0000, 10);
    set_op(C_MOV, 32'd0, 32'hABCD, 1'b0);
    wb_en_in = 1'b1;
    settle();
    check("post_flush_busy", busy, 0);
    tick();
    check("post_flush_res", alu_res, 32'hABCD);

    // Hold freezes the output register until released.
    set_op(C_ADD, 32'd10, 32'd20, 1'b0);
    tick();
    check("hold_pre", alu_res, 30);
    set_op(C_ADD, 32'd1, 32'd2, 1'b1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("hold_busy", busy, 1);
      check("hold_swr", status_wr, 0);
      tick();
      check("hold_frozen", alu_res, 30);
      check("hold_wb", wb_en_out, 1);
    end
    hold = 1'b0;
    settle();
    check("hold_release_swr", status_wr, 1);
    tick();
    check("hold_release_res", alu_res, 3);
    in_valid = 1'b0;

    // Branch target wraps with a negative offset.
    pc_in = 32'h100; signed_imm_24 = 24'hFF_FFFF;
    settle();
    check("branch", branch_addr, 32'hFC);
    tick();

    // Asynchronous reset in the middle of a MUL.
    set_op(C_MUL, 32'd3, 32'd7, 1'b1);
    dest_in = 4'd9; val_r_m_in = 32'h55;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_res", alu_res, 0);
    check("midrst_store", val_r_m_out, 0);
    check("midrst_dest", dest_out, 0);
    check("midrst_ctrl", {wb_en_out, mem_r_en_out, mem_w_en_out}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_swr", status_wr, 0);
    #1 rst_n = 1'b1;
    tick();
    set_op(C_MOV, 32'd0, 32'h77, 1'b0);
    settle();
    check("post_rst_busy", busy, 0);
    tick();
    check("post_rst_res", alu_res, 32'h77);
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
